// File: rtl/exe_mem_pipereg_elastic.sv
// rtl/exe_mem_pipereg_elastic.sv - EXE->MEM elastic stage register with 2-entry skid buffer and flush
// Optional feature: define EXE_MEM_STALL_CNT_EN to build the saturating MEM-side stall counter.
module exe_mem_pipereg_elastic #(
    parameter int WORD_LEN     = 32,
    parameter int REG_ADDR_LEN = 5,
    parameter int PC_LEN       = 32,
    parameter int STALL_CNT_W  = 16
) (
    input  logic                    i_sys_clk,
    input  logic                    i_sys_rst,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic                    i_flush,
    input  logic                    i_writeback_en_in,
    input  logic                    i_MEM_Rd_en,
    input  logic                    i_MEM_Wr_en,
    input  logic [REG_ADDR_LEN-1:0] i_dest_in,
    input  logic [PC_LEN-1:0]       i_PC_in,
    input  logic [WORD_LEN-1:0]     i_ALU_result_in,
    input  logic [WORD_LEN-1:0]     i_STvalue_in,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic                    o_writeback_en_out,
    output logic                    o_MEM_Rd_en,
    output logic                    o_MEM_Wr_en,
    output logic [REG_ADDR_LEN-1:0] o_dest_out,
    output logic [PC_LEN-1:0]       o_PC_out,
    output logic [WORD_LEN-1:0]     o_ALU_result_out,
    output logic [WORD_LEN-1:0]     o_STvalue_out,
    output logic                    o_err_rdwr,
    output logic [STALL_CNT_W-1:0]  o_stall_cnt
);

    localparam int PW = 3 + REG_ADDR_LEN + PC_LEN + 2 * WORD_LEN;

    logic [PW-1:0] in_pl;
    logic [PW-1:0] m_pl;
    logic [PW-1:0] s_pl;
    logic          m_valid;
    logic          s_valid;
    logic          ready_q;
    logic          err_q;
    logic          accept;
    logic          drain;
    logic          m_wb;
    logic          m_rd;
    logic          m_wr;

    assign in_pl  = {i_writeback_en_in, i_MEM_Rd_en, i_MEM_Wr_en, i_dest_in,
                     i_PC_in, i_ALU_result_in, i_STvalue_in};
    assign accept = i_valid & ready_q;
    assign drain  = m_valid & i_ready;

    // ready_q always mirrors ~s_valid; kept as its own flop so i_ready never reaches o_ready.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            ready_q <= 1'b1;
            m_pl    <= '0;
            s_pl    <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept && i_MEM_Rd_en && i_MEM_Wr_en && !i_flush) begin
                err_q <= 1'b1;
            end
            if (i_flush) begin
                m_valid <= 1'b0;
                s_valid <= 1'b0;
                ready_q <= 1'b1;
            end else if (drain && s_valid) begin
                m_pl    <= s_pl;
                s_valid <= 1'b0;
                ready_q <= 1'b1;
            end else if (accept && (!m_valid || drain)) begin
                m_pl    <= in_pl;
                m_valid <= 1'b1;
            end else if (accept) begin
                s_pl    <= in_pl;
                s_valid <= 1'b1;
                ready_q <= 1'b0;
            end else if (drain) begin
                m_valid <= 1'b0;
            end
        end
    end

    assign {m_wb, m_rd, m_wr, o_dest_out, o_PC_out, o_ALU_result_out, o_STvalue_out} = m_pl;

    // Strobes are gated so a bubble or flushed entry cannot write RF or memory.
    assign o_valid            = m_valid;
    assign o_ready            = ready_q;
    assign o_writeback_en_out = m_wb & m_valid;
    assign o_MEM_Rd_en        = m_rd & m_valid;
    assign o_MEM_Wr_en        = m_wr & m_valid;
    assign o_err_rdwr         = err_q;

`ifdef EXE_MEM_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_q;

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            stall_q <= '0;
        end else if (m_valid && !i_ready && !(&stall_q)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign o_stall_cnt = stall_q;
`else
    assign o_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_exe_mem_pipereg_elastic.sv
// tb/tb_exe_mem_pipereg_elastic.sv - self-checking bench for exe_mem_pipereg_elastic against a queue model
module tb_exe_mem_pipereg_elastic;

    localparam int W  = 32;
    localparam int RA = 5;
    localparam int PL = 32;
    localparam int SC = 4;

    typedef struct packed {
        logic          wb;
        logic          rd;
        logic          wr;
        logic [RA-1:0] dest;
        logic [PL-1:0] pc;
        logic [W-1:0]  alu;
        logic [W-1:0]  st;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_valid, i_flush, i_ready;
    logic          i_wb, i_rd, i_wr;
    logic [RA-1:0] i_dest;
    logic [PL-1:0] i_pc;
    logic [W-1:0]  i_alu, i_st;
    logic          o_valid, o_ready, o_wb, o_rd, o_wr, o_err;
    logic [RA-1:0] o_dest;
    logic [PL-1:0] o_pc;
    logic [W-1:0]  o_alu, o_st;
    logic [SC-1:0] o_stall;

    int checks   = 0;
    int failures = 0;

    ent_t       q[$];
    ent_t       last_m;
    logic       m_err;
    int         m_stall;
    logic       seen_pc20;

    exe_mem_pipereg_elastic #(
        .WORD_LEN(W), .REG_ADDR_LEN(RA), .PC_LEN(PL), .STALL_CNT_W(SC)
    ) dut (
        .i_sys_clk(clk), .i_sys_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_flush(i_flush), .i_writeback_en_in(i_wb), .i_MEM_Rd_en(i_rd),
        .i_MEM_Wr_en(i_wr), .i_dest_in(i_dest), .i_PC_in(i_pc),
        .i_ALU_result_in(i_alu), .i_STvalue_in(i_st), .o_valid(o_valid),
        .i_ready(i_ready), .o_writeback_en_out(o_wb), .o_MEM_Rd_en(o_rd),
        .o_MEM_Wr_en(o_wr), .o_dest_out(o_dest), .o_PC_out(o_pc),
        .o_ALU_result_out(o_alu), .o_STvalue_out(o_st), .o_err_rdwr(o_err),
        .o_stall_cnt(o_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an ordered FIFO of at most two held entries; the head is what the outputs show.
    always @(posedge clk) begin
        bit   acc, drn;
        ent_t e;
        if (rst) begin
            q.delete();
            last_m  = '0;
            m_err   = 1'b0;
            m_stall = 0;
        end else begin
            acc = i_valid && (q.size() < 2);
            drn = (q.size() > 0) && i_ready;
            if (q.size() > 0 && !i_ready && m_stall < (1 << SC) - 1) m_stall++;
            if (acc && i_rd && i_wr && !i_flush) m_err = 1'b1;
            if (i_flush) begin
                q.delete();
            end else begin
                if (drn) void'(q.pop_front());
                if (acc) begin
                    e = '{wb: i_wb, rd: i_rd, wr: i_wr, dest: i_dest, pc: i_pc, alu: i_alu, st: i_st};
                    q.push_back(e);
                end
            end
            if (q.size() > 0) last_m = q[0];
        end
    end

    always @(negedge clk) begin
        logic mv;
        mv = q.size() > 0;
        chk("o_valid", 64'(o_valid), 64'(mv));
        chk("o_ready", 64'(o_ready), 64'(q.size() < 2));
        chk("o_wb", 64'(o_wb), 64'(last_m.wb & mv));
        chk("o_rd", 64'(o_rd), 64'(last_m.rd & mv));
        chk("o_wr", 64'(o_wr), 64'(last_m.wr & mv));
        chk("o_dest", 64'(o_dest), 64'(last_m.dest));
        chk("o_pc", 64'(o_pc), 64'(last_m.pc));
        chk("o_alu", 64'(o_alu), 64'(last_m.alu));
        chk("o_st", 64'(o_st), 64'(last_m.st));
        chk("o_err", 64'(o_err), 64'(m_err));
`ifdef EXE_MEM_STALL_CNT_EN
        chk("o_stall", 64'(o_stall), 64'(m_stall));
`else
        chk("o_stall", 64'(o_stall), 64'd0);
`endif
        if (o_valid && o_pc == 32'h20) seen_pc20 = 1'b1;
    end

    task automatic drive(input logic v, input logic wb, input logic rd, input logic wr,
                         input logic [RA-1:0] d, input logic [PL-1:0] pc);
        i_valid = v; i_wb = wb; i_rd = rd; i_wr = wr; i_dest = d; i_pc = pc;
        i_alu = pc + 32'h1000; i_st = ~pc;
        @(negedge clk);
    endtask

    initial begin
        seen_pc20 = 1'b0;
        rst = 1'b1; i_flush = 1'b0; i_ready = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("rst_ready", 64'(o_ready), 64'd1);
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_pc", 64'(o_pc), 64'd0);
        rst = 1'b0;

        // Back-to-back stream, outputs trail input by one cycle.
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 0, 0, 5'(i + 1), 32'(4 * i));
            chk("b2b_pc", 64'(o_pc), 64'(4 * i));
            chk("b2b_ready", 64'(o_ready), 64'd1);
        end
        drive(0, 0, 0, 0, 0, 0);
        chk("b2b_empty", 64'(o_valid), 64'd0);

        // Skid: second entry lands in S while MEM stalls, then both drain in order.
        drive(1, 0, 1, 0, 5'd2, 32'h10);
        i_ready = 1'b0;
        drive(1, 0, 0, 1, 5'd3, 32'h14);
        chk("skid_ready", 64'(o_ready), 64'd0);
        chk("skid_head", 64'(o_pc), 64'h10);
        drive(0, 0, 0, 0, 0, 0);
        chk("skid_hold", 64'(o_pc), 64'h10);
        i_ready = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        chk("skid_second", 64'(o_pc), 64'h14);
        chk("skid_ready1", 64'(o_ready), 64'd1);
        drive(0, 0, 0, 0, 0, 0);
        chk("skid_done", 64'(o_valid), 64'd0);

        // Flush with both held and an incoming entry.
        i_ready = 1'b0;
        drive(1, 1, 1, 0, 5'd4, 32'h18);
        drive(1, 1, 0, 1, 5'd6, 32'h1C);
        chk("fl_full", 64'(o_ready), 64'd0);
        i_flush = 1'b1;
        i_valid = 1'b1; i_pc = 32'h20;
        @(negedge clk);
        i_flush = 1'b0;
        chk("fl_valid", 64'(o_valid), 64'd0);
        chk("fl_wb", 64'(o_wb), 64'd0);
        chk("fl_rd", 64'(o_rd), 64'd0);
        chk("fl_wr", 64'(o_wr), 64'd0);
        chk("fl_ready", 64'(o_ready), 64'd1);
        i_ready = 1'b1;
        repeat (3) drive(0, 0, 0, 0, 0, 0);
        chk("fl_pc20_never", 64'(seen_pc20), 64'd0);

        // Sticky Rd/Wr conflict error, cleared only by reset.
        drive(1, 0, 1, 1, 5'd5, 32'h24);
        chk("err_set", 64'(o_err), 64'd1);
        chk("err_rd", 64'(o_rd), 64'd1);
        repeat (10) drive(0, 0, 0, 0, 0, 0);
        chk("err_sticky", 64'(o_err), 64'd1);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        chk("err_clr", 64'(o_err), 64'd0);

        // Bubble gating with held data.
        drive(1, 1, 0, 0, 5'd7, 32'h28);
        chk("wb_on", 64'(o_wb), 64'd1);
        repeat (3) drive(0, 0, 0, 0, 0, 0);
        chk("wb_gated", 64'(o_wb), 64'd0);
        chk("dest_held", 64'(o_dest), 64'd7);

        // Stall counter saturation.
        i_ready = 1'b0;
        drive(1, 0, 0, 0, 5'd8, 32'h2C);
        repeat (20) drive(0, 0, 0, 0, 0, 0);
`ifdef EXE_MEM_STALL_CNT_EN
        chk("stall_sat", 64'(o_stall), 64'd15);
`else
        chk("stall_off", 64'(o_stall), 64'd0);
`endif
        chk("stall_hold_pc", 64'(o_pc), 64'h2C);
        i_ready = 1'b1;
        drive(0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
